pane_fetch_unit: RTL and testbench
==================================

Name: pane_fetch_unit

Overview:
VGA-path pixel fetcher. It sweeps an image ROM sequentially, one 24-bit RGB word per address, and pushes the words into the downstream pixel FIFO. The block sits between the image ROM, which has a synchronous 1-cycle read, and the display FIFO. It throttles on the FIFO almost-full flag and wraps at the end of the pane so frames repeat.

Parameters:
- PANE_WIDTH, 640, pixels per line.
- PANE_HEIGHT, 480, lines per pane.
- PANE_PIXELS, PANE_WIDTH*PANE_HEIGHT, wrap point for the address (last address = PANE_PIXELS-1); must be ≤ 2^24.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- rom_data  in  24  ROM read data; equals mem[address presented on the previous edge].
- empty  in  1  FIFO empty flag; status only, no functional effect in this revision.
- full  in  1  FIFO almost-full flag; FIFO guarantees ≥2 free entries while full is high.
- write_en  out  1  FIFO push strobe, registered.
- display_addr  out  24  ROM read address, registered.
- data_out  out  24  FIFO write data, registered, valid when write_en=1.

Behaviour:
- Single clock domain. Reset is synchronous and active-high, using ports clk and rst as named above.
- Reset values: display_addr=0, write_en=0, data_out=0, internal valid bits v0=0 and v1=0.
- Reset mid-operation discards all in-flight words. No write_en occurs in the cycle after reset.
- v0=1 means display_addr is a live request this cycle. v1=1 means rom_data is valid this cycle.
- Edge rules when not in reset:
  - Address advance: if v0=1, display_addr <= (display_addr==PANE_PIXELS-1) ? 0 : display_addr+1. Otherwise display_addr holds.
  - Request issue: v0 <= ~full.
  - Pipeline: v1 <= v0.
  - Output: write_en <= v1; data_out <= rom_data when v1=1, otherwise data_out holds.
- Consequences of these rules:
  - Each address is requested exactly once per frame: no duplicates and no skips across full stalls.
  - Latency from an address being live to write_en for its word is 2 edges.
  - Sustained throughput is 1 word/clk while full=0.
  - After full is first sampled high, at most 2 further writes occur as the pipeline drains.
  - After full drops, the first write occurs 2 edges after the first new request.
- Wrap: after address PANE_PIXELS-1 the next request is address 0, with no bubble.
- Simultaneous full rise and wrap: the address still advances to 0; the request for 0 waits until full=0.
- ROM contract (rom block): registered read rom_data <= mem[addr] on each edge. rst clears rom_data to 0. Contents are preloaded from an image file at elaboration.
- No combinational path from any input to any output.

Test Plan:
- Reset, then full=0 for 512 clks. After the first edge with rst=0: display_addr=0,1,2,… one per clk. write_en first high 3 edges after rst drop, then continuous. The n-th write carries data_out=mem[n].
- rst held high for several clks -> write_en=0, display_addr=0, data_out=0 every cycle. Release -> same timing as the previous scenario.
- Pulse full high for 5 clks mid-stream -> address freezes while full is sampled high; ≤2 writes after full first sampled high. Resume with the next unrequested address; the written sequence stays mem[0],mem[1],… with no gap or repeat.
- PANE_WIDTH=4, PANE_HEIGHT=2, full=0 -> display_addr 0..7,0,1,… and the write data sequence wraps identically with no bubble.
- Full toggling every cycle -> written sequence still strictly consecutive. Check against a ROM with mem[i]=i.
- Assert rst with words in flight -> next cycle write_en=0 and display_addr=0; the restarted sequence begins at mem[0].

Source files
------------

// File: rtl/pane_fetch_unit.sv
// +----------------------------------------------------------------------------+
// | pane_fetch_unit: sweeps an image ROM address by address and pushes each    |
// | 24-bit RGB word into the display FIFO, wrapping at the end of the pane.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module pane_fetch_unit #(
   parameter int PANE_WIDTH  = 640,
   parameter int PANE_HEIGHT = 480,
   parameter int PANE_PIXELS = PANE_WIDTH * PANE_HEIGHT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [23:0] rom_data,
   input  logic        empty,
   input  logic        full,
   output logic        write_en,
   output logic [23:0] display_addr,
   output logic [23:0] data_out
);

   localparam logic [23:0] LAST_ADDR = 24'(PANE_PIXELS - 1);

   logic        req_live;
   logic        rom_valid;
   logic [23:0] next_addr;
   logic        unused_empty;

   // The FIFO empty flag is carried for status only and steers nothing.
   assign unused_empty = empty;

   always_comb begin
      next_addr = display_addr + 24'd1;
      if (display_addr == LAST_ADDR) begin
         next_addr = '0;
      end
   end

   // An address advances only once its request has been issued, so a full
   // stall never skips or repeats a pixel; the two-entry FIFO headroom
   // absorbs the words already in the ROM pipeline.
   always_ff @(posedge clk) begin
      if (rst) begin
         display_addr <= '0;
         req_live     <= 1'b0;
         rom_valid    <= 1'b0;
         write_en     <= 1'b0;
         data_out     <= '0;
      end else begin
         if (req_live) begin
            display_addr <= next_addr;
         end
         req_live  <= ~full;
         rom_valid <= req_live;
         write_en  <= rom_valid;
         if (rom_valid) begin
            data_out <= rom_data;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_pane_fetch_unit.sv
// +----------------------------------------------------------------------------+
// | tb_pane_fetch_unit: checks a full-size and a 4x2 pane fetcher side by side |
// | with ROM models. Revision: 1.0                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_pane_fetch_unit;

   localparam int S_PIX = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic        full;
   logic        empty;
   logic [23:0] rom_b, rom_s;
   logic [23:0] addr_b, addr_s;
   logic [23:0] data_b, data_s;
   logic        we_b, we_s;

   int tests = 0;
   int fails = 0;
   int exp_b = 0;
   int exp_s = 0;

   always #5 clk = ~clk;

   pane_fetch_unit u_big (
      .clk(clk), .rst(rst), .rom_data(rom_b), .empty(empty), .full(full),
      .write_en(we_b), .display_addr(addr_b), .data_out(data_b)
   );

   pane_fetch_unit #(.PANE_WIDTH(4), .PANE_HEIGHT(2)) u_small (
      .clk(clk), .rst(rst), .rom_data(rom_s), .empty(empty), .full(full),
      .write_en(we_s), .display_addr(addr_s), .data_out(data_s)
   );

   function automatic logic [23:0] mem_f(input logic [23:0] a);
      return a ^ 24'hA50000;
   endfunction

   function automatic logic [23:0] dexp(input int i);
      return (i < 0) ? 24'd0 : mem_f(24'(i));
   endfunction

   // Registered-read ROM models, cleared by reset.
   always @(posedge clk) begin
      if (rst) begin
         rom_b <= '0;
         rom_s <= '0;
      end else begin
         rom_b <= mem_f(addr_b);
         rom_s <= mem_f(addr_s);
      end
   end

   task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Every write must carry the next consecutive pixel of its pane.
   task automatic sb_step(input string tag);
      if (we_b) begin
         check({tag, " data_b"}, data_b, dexp(exp_b));
         exp_b++;
      end
      if (we_s) begin
         check({tag, " data_s"}, data_s, dexp(exp_s));
         exp_s = (exp_s + 1) % S_PIX;
      end
   endtask

   typedef struct {
      logic rst;
      logic full;
      logic we;
      int   ab;
      int   as_;
      int   db;
      int   ds;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic r, input logic f, input logic w,
                      input int ab, input int as_, input int db, input int ds);
      vec_t v;
      v.rst = r; v.full = f; v.we = w; v.ab = ab; v.as_ = as_; v.db = db; v.ds = ds;
      tbl.push_back(v);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      logic [23:0] pb;
      logic [23:0] ps;
      logic        ok;

      rst   = 1'b1;
      full  = 1'b0;
      empty = 1'b0;

      // rst full we addr_big addr_small data_idx_big data_idx_small
      add(1,0,0, 0,0,-1,-1);  add(1,0,0, 0,0,-1,-1);
      add(0,0,0, 0,0,-1,-1);  add(0,0,0, 1,1,-1,-1);
      add(0,0,1, 2,2, 0,0);   add(0,0,1, 3,3, 1,1);
      add(0,0,1, 4,4, 2,2);   add(0,0,1, 5,5, 3,3);
      add(0,0,1, 6,6, 4,4);   add(0,0,1, 7,7, 5,5);
      add(0,0,1, 8,0, 6,6);   add(0,0,1, 9,1, 7,7);
      add(0,0,1,10,2, 8,0);   add(0,0,1,11,3, 9,1);
      // full held for five edges: two draining writes, address frozen
      add(0,1,1,12,4,10,2);   add(0,1,1,12,4,11,3);
      add(0,1,0,12,4,11,3);   add(0,1,0,12,4,11,3);
      add(0,1,0,12,4,11,3);
      add(0,0,0,12,4,11,3);   add(0,0,0,13,5,11,3);
      add(0,0,1,14,6,12,4);   add(0,0,1,15,7,13,5);
      add(0,0,1,16,0,14,6);
      // reset with words in flight, then restart from pixel 0
      add(1,0,0, 0,0,-1,-1);
      add(0,0,0, 0,0,-1,-1);  add(0,0,0, 1,1,-1,-1);
      add(0,0,1, 2,2, 0,0);   add(0,0,1, 3,3, 1,1);
      add(0,0,1, 4,4, 2,2);   add(0,0,1, 5,5, 3,3);
      add(0,0,1, 6,6, 4,4);   add(0,0,1, 7,7, 5,5);
      // full rises on the same edge the small pane wraps
      add(0,1,1, 8,0, 6,6);   add(0,1,1, 8,0, 7,7);
      add(0,0,0, 8,0, 7,7);   add(0,0,0, 9,1, 7,7);
      add(0,0,1,10,2, 8,0);

      for (int i = 0; i < tbl.size(); i++) begin
         rst  = tbl[i].rst;
         full = tbl[i].full;
         tick();
         check($sformatf("v%0d we_b", i),   24'(we_b),   24'(tbl[i].we));
         check($sformatf("v%0d we_s", i),   24'(we_s),   24'(tbl[i].we));
         check($sformatf("v%0d addr_b", i), addr_b,      24'(tbl[i].ab));
         check($sformatf("v%0d addr_s", i), addr_s,      24'(tbl[i].as_));
         check($sformatf("v%0d data_b", i), data_b,      dexp(tbl[i].db));
         check($sformatf("v%0d data_s", i), data_s,      dexp(tbl[i].ds));
      end

      exp_b = 9;
      exp_s = 1;

      // full toggling every cycle
      for (int i = 0; i < 100; i++) begin
         full  = i[0];
         empty = $urandom_range(0, 1) == 1;
         pb = addr_b;
         ps = addr_s;
         tick();
         sb_step("tog");
         ok = (addr_b == pb) || (addr_b == pb + 24'd1);
         check("tog step_b", 24'(ok), 24'd1);
         ok = (addr_s == ps) || (addr_s == 24'((int'(ps) + 1) % S_PIX));
         check("tog step_s", 24'(ok), 24'd1);
      end

      // long free-running stretch: one word per clock after the pipeline fills
      full = 1'b0;
      for (int i = 0; i < 512; i++) begin
         pb = addr_b;
         ps = addr_s;
         tick();
         sb_step("run");
         if (i >= 2) begin
            check("run we_b", 24'(we_b), 24'd1);
            check("run we_s", 24'(we_s), 24'd1);
         end
         if (i >= 1) begin
            check("run addr_b", addr_b, pb + 24'd1);
            check("run addr_s", addr_s, 24'((int'(ps) + 1) % S_PIX));
         end
      end

      // reset held for several clocks mid-stream
      rst = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("hold we_b",   24'(we_b), 24'd0);
         check("hold addr_b", addr_b,    24'd0);
         check("hold data_b", data_b,    24'd0);
         check("hold addr_s", addr_s,    24'd0);
      end
      rst = 1'b0;
      exp_b = 0;
      exp_s = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         check("rel we_b", 24'(we_b), 24'(i >= 2));
         check("rel addr_b", addr_b, 24'(i));
         sb_step("rel");
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

`default_nettype wire
